// File: rtl/cpu_gregs_ctx_seq.sv
// Trap-context sequencer for the general register file.
// Saves x1..x(GREG_COUNT-1) to a memory save area or restores them from it.
// While busy it owns the GRF ports (grf_owned) and the data-memory port.
module cpu_gregs_ctx_seq #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     GREG_COUNT = 32,
    parameter int unsigned     IDX_W      = 5,
    parameter logic [XLEN-1:0] SAVE_BASE  = XLEN'('h7ff00)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             save_req,
    input  logic             restore_req,
    output logic             busy,
    output logic             done,
    output logic             grf_owned,
    output logic [IDX_W-1:0] grf_rd_idx,
    input  logic [XLEN-1:0]  grf_rd_dat,
    output logic             grf_wr_en,
    output logic [IDX_W-1:0] grf_wr_idx,
    output logic [XLEN-1:0]  grf_wr_dat,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdat,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdat
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        R_RD   = 3'd4,
        R_WR   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(GREG_COUNT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]  data_q, data_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] grf_rd_idx_q, grf_rd_idx_d;
    logic             grf_wr_en_q, grf_wr_en_d;
    logic [IDX_W-1:0] grf_wr_idx_q, grf_wr_idx_d;
    logic [XLEN-1:0]  grf_wr_dat_q, grf_wr_dat_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]  mem_wdat_q, mem_wdat_d;

    logic             idx_is_last;

    assign idx_is_last = (idx_q == IDX_LAST);

    // Next-state, index and data-register sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (save_req) begin
                    state_d = S_RD;
                    idx_d   = IDX_FIRST;
                end else if (restore_req) begin
                    state_d = R_RD;
                    idx_d   = IDX_FIRST;
                end
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: begin
                data_d  = grf_rd_dat;
                state_d = S_WR;
            end
            S_WR: begin
                if (mem_ack) begin
                    if (idx_is_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            R_RD: begin
                if (mem_ack) begin
                    data_d  = mem_rdat;
                    state_d = R_WR;
                end
            end
            R_WR: begin
                if (idx_is_last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = R_RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        grf_rd_idx_d = (state_d == S_RD) ? idx_d : '0;
        grf_wr_en_d  = (state_d == R_WR);
        grf_wr_idx_d = (state_d == R_WR) ? idx_d : '0;
        grf_wr_dat_d = (state_d == R_WR) ? data_d : '0;
        mem_req_d    = (state_d == S_WR) || (state_d == R_RD);
        mem_we_d     = (state_d == S_WR);
        mem_addr_d   = mem_req_d ? (SAVE_BASE + {{(XLEN-IDX_W-2){1'b0}}, idx_d, 2'b00}) : '0;
        mem_wdat_d   = (state_d == S_WR) ? data_d : '0;
    end

    // State and registered outputs; reset aborts any sequence immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= IDX_FIRST;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            grf_rd_idx_q <= '0;
            grf_wr_en_q  <= 1'b0;
            grf_wr_idx_q <= '0;
            grf_wr_dat_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdat_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            grf_rd_idx_q <= grf_rd_idx_d;
            grf_wr_en_q  <= grf_wr_en_d;
            grf_wr_idx_q <= grf_wr_idx_d;
            grf_wr_dat_q <= grf_wr_dat_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdat_q   <= mem_wdat_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign grf_owned  = busy_q;
    assign grf_rd_idx = grf_rd_idx_q;
    assign grf_wr_en  = grf_wr_en_q;
    assign grf_wr_idx = grf_wr_idx_q;
    assign grf_wr_dat = grf_wr_dat_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdat   = mem_wdat_q;

endmodule

// File: tb/tb_cpu_gregs_ctx_seq.sv
// Directed bench for cpu_gregs_ctx_seq with a GRF model (one-cycle read
// latency) and a save-area memory model with programmable ack delay.
module tb_cpu_gregs_ctx_seq;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;
    localparam logic [31:0] SAVE_BASE = 32'h7ff00;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             save_req = 1'b0;
    logic             restore_req = 1'b0;
    logic             busy, done, grf_owned;
    logic [IDX_W-1:0] grf_rd_idx;
    logic [XLEN-1:0]  grf_rd_dat = '0;
    logic             grf_wr_en;
    logic [IDX_W-1:0] grf_wr_idx;
    logic [XLEN-1:0]  grf_wr_dat;
    logic             mem_req, mem_we;
    logic [XLEN-1:0]  mem_addr, mem_wdat;
    logic             mem_ack = 1'b0;
    logic [XLEN-1:0]  mem_rdat = '0;

    cpu_gregs_ctx_seq #(
        .XLEN(32), .GREG_COUNT(32), .IDX_W(5), .SAVE_BASE(32'h7ff00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .save_req(save_req), .restore_req(restore_req),
        .busy(busy), .done(done), .grf_owned(grf_owned),
        .grf_rd_idx(grf_rd_idx), .grf_rd_dat(grf_rd_dat),
        .grf_wr_en(grf_wr_en), .grf_wr_idx(grf_wr_idx), .grf_wr_dat(grf_wr_dat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .mem_ack(mem_ack), .mem_rdat(mem_rdat)
    );

    always #5 clk = ~clk;

    logic [31:0] grf [32];
    logic [31:0] slot [32];

    int n_cmp = 0, n_bad = 0;
    int busy_cycles, done_cnt, done_at, save_cnt, read_cnt, wr_cnt, x0_wr;
    int order_err, unstable, own_err, exp_wr, exp_mem;
    int ack_delay = 0, wait_cnt = 0;
    logic idle_ack = 1'b0;
    logic req_active = 1'b0;
    logic first_seen;
    logic [31:0] first_addr;
    logic first_we;
    logic [31:0] h_addr, h_wdat, off;
    logic h_we;
    logic [4:0] rd_lat = '0;
    logic [4:0] sidx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        busy_cycles = 0; done_cnt = 0; done_at = 0; save_cnt = 0; read_cnt = 0;
        wr_cnt = 0; x0_wr = 0; order_err = 0; unstable = 0; own_err = 0;
        exp_wr = 1; exp_mem = 1; first_seen = 1'b0; first_addr = '0; first_we = 1'b0;
    endtask

    // GRF and memory models, all activity on the falling edge
    always @(negedge clk) begin
        if (grf_owned !== busy) own_err++;
        if (busy) busy_cycles++;
        if (done) begin
            done_cnt++;
            done_at = busy_cycles;
        end
        if (grf_wr_en) begin
            if (grf_wr_idx == 5'd0) x0_wr++;
            if (int'(grf_wr_idx) != exp_wr) order_err++;
            exp_wr++;
            grf[grf_wr_idx] = grf_wr_dat;
            wr_cnt++;
        end
        grf_rd_dat = grf[rd_lat];
        rd_lat = grf_rd_idx;
        if (mem_req) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                first_addr = mem_addr;
                first_we = mem_we;
            end
            if (req_active) begin
                if (mem_addr !== h_addr || mem_we !== h_we || mem_wdat !== h_wdat) unstable++;
            end else begin
                req_active = 1'b1;
                h_addr = mem_addr; h_we = mem_we; h_wdat = mem_wdat;
            end
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                wait_cnt = 0;
                req_active = 1'b0;
                off = mem_addr - SAVE_BASE;
                sidx = off[6:2];
                if (int'(sidx) != exp_mem || off[1:0] != 2'b00 || off > 32'd124) order_err++;
                exp_mem++;
                if (mem_we) begin
                    slot[sidx] = mem_wdat;
                    save_cnt++;
                end else begin
                    mem_rdat = slot[sidx];
                    read_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack = idle_ack;
            wait_cnt = 0;
            req_active = 1'b0;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic r);
        save_req = s;
        restore_req = r;
        cyc();
        save_req = 1'b0;
        restore_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(done_cnt >= 1 && !busy) && n < budget) begin
            cyc();
            n++;
        end
        check({tag, "_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        clear_stats();
        for (int i = 0; i < 32; i++) begin
            grf[i] = '0;
            slot[i] = '0;
        end

        // Reset state
        repeat (2) cyc();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        reset_n = 1'b1;
        repeat (2) cyc();
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_owned", 32'(grf_owned), 0);
        check("idle_wr_en", 32'(grf_wr_en), 0);
        check("idle_addr", mem_addr, 0);

        // 1: zero-wait save
        for (int i = 0; i < 32; i++) grf[i] = 32'hA000_0000 + 32'(i);
        clear_stats();
        ack_delay = 0;
        pulse(1'b1, 1'b0);
        wait_idle("save0", 300);
        check("save0_cnt", 32'(save_cnt), 31);
        check("save0_x1", slot[1], 32'hA000_0001);
        check("save0_x31", slot[31], 32'hA000_001F);
        check("save0_x0_untouched", slot[0], 32'h0);
        check("save0_done_at", 32'(done_at), 94);
        check("save0_busy_len", 32'(busy_cycles), 94);
        check("save0_done_cnt", 32'(done_cnt), 1);
        check("save0_order", 32'(order_err), 0);
        check("save0_no_grf_wr", 32'(wr_cnt), 0);
        check("save0_owned", 32'(own_err), 0);

        // 2: zero-wait restore
        for (int i = 0; i < 32; i++) begin
            slot[i] = ~(32'(i));
            grf[i] = '0;
        end
        grf[0] = 32'h5A5A_5A5A;
        clear_stats();
        pulse(1'b0, 1'b1);
        wait_idle("rest0", 300);
        check("rest0_wr_cnt", 32'(wr_cnt), 31);
        check("rest0_x1", grf[1], 32'hFFFF_FFFE);
        check("rest0_x31", grf[31], 32'hFFFF_FFE0);
        check("rest0_x0_kept", grf[0], 32'h5A5A_5A5A);
        check("rest0_x0_writes", 32'(x0_wr), 0);
        check("rest0_order", 32'(order_err), 0);
        check("rest0_done_at", 32'(done_at), 63);
        check("rest0_busy_len", 32'(busy_cycles), 63);
        check("rest0_first_we", 32'(first_we), 0);

        // 3: three wait cycles on every ack
        for (int i = 0; i < 32; i++) begin
            grf[i] = 32'hA000_0000 + 32'(i);
            slot[i] = '0;
        end
        clear_stats();
        ack_delay = 3;
        pulse(1'b1, 1'b0);
        wait_idle("save3", 600);
        check("save3_busy_len", 32'(busy_cycles), 187);
        check("save3_done_at", 32'(done_at), 187);
        check("save3_stable", 32'(unstable), 0);
        check("save3_x17", slot[17], 32'hA000_0011);
        check("save3_order", 32'(order_err), 0);
        ack_delay = 0;

        // 4: simultaneous requests, save wins; restore during busy ignored
        clear_stats();
        pulse(1'b1, 1'b1);
        repeat (10) cyc();
        pulse(1'b0, 1'b1);
        wait_idle("both", 300);
        repeat (20) cyc();
        check("both_first_we", 32'(first_we), 1);
        check("both_save_cnt", 32'(save_cnt), 31);
        check("both_read_cnt", 32'(read_cnt), 0);
        check("both_done_cnt", 32'(done_cnt), 1);
        check("both_busy_len", 32'(busy_cycles), 94);

        // 5: reset during S_WR at idx 7
        clear_stats();
        ack_delay = 4;
        pulse(1'b1, 1'b0);
        begin
            int n = 0;
            while (!(mem_req && mem_we && mem_addr == SAVE_BASE + 32'd28) && n < 500) begin
                cyc();
                n++;
            end
            check("rst7_reached", 32'(n < 500), 1);
        end
        check("rst7_saved_before", 32'(save_cnt), 6);
        #2 reset_n = 1'b0;
        #1;
        check("rst7_mem_req", 32'(mem_req), 0);
        check("rst7_busy", 32'(busy), 0);
        check("rst7_done", 32'(done), 0);
        check("rst7_wr_en", 32'(grf_wr_en), 0);
        repeat (3) cyc();
        reset_n = 1'b1;
        clear_stats();
        repeat (5) cyc();
        check("rst7_idle_busy", 32'(busy), 0);
        check("rst7_idle_activity", 32'(save_cnt + done_cnt + busy_cycles), 0);
        ack_delay = 0;
        pulse(1'b1, 1'b0);
        wait_idle("rst7_resave", 300);
        check("rst7_first_addr", first_addr, SAVE_BASE + 32'd4);
        check("rst7_save_cnt", 32'(save_cnt), 31);
        check("rst7_done_at", 32'(done_at), 94);

        // 6: mem_ack while idle
        clear_stats();
        idle_ack = 1'b1;
        repeat (4) cyc();
        check("iack_busy", 32'(busy), 0);
        check("iack_mem_req", 32'(mem_req), 0);
        check("iack_done", 32'(done), 0);
        check("iack_wr_en", 32'(grf_wr_en), 0);
        check("iack_activity", 32'(busy_cycles + done_cnt + wr_cnt), 0);
        idle_ack = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
